// File: rtl/peripheral_arbiter_axi4.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_arbiter_axi4
// Purpose  : Round-robin arbiter sharing one AXI4 slave port among
//            NUM_MASTERS upstream masters. Write (AW/W/B) and read (AR/R)
//            paths are arbitrated independently, one outstanding transaction
//            per path, locked to the granted master until the final response.
// Ports    : aclk/aresetn          clock, async active-low reset
//            s_aw_*/s_w_*/s_b_*    master-side write channels (NM slices)
//            s_ar_*/s_r_*          master-side read channels (NM slices)
//            m_aw_*/m_w_*/m_b_*    slave-side write channels
//            m_ar_*/m_r_*          slave-side read channels
//            wr_grant/rd_grant     registered one-hot grants, zero when idle
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_arbiter_axi4 #(
  parameter int NUM_MASTERS = 2
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NUM_MASTERS*54-1:0] s_aw_pld,
  input  logic [NUM_MASTERS-1:0]    s_awvalid,
  output logic [NUM_MASTERS-1:0]    s_awready,
  input  logic [NUM_MASTERS*41-1:0] s_w_pld,
  input  logic [NUM_MASTERS-1:0]    s_wvalid,
  output logic [NUM_MASTERS-1:0]    s_wready,
  output logic [5:0]                s_b_pld,
  output logic [NUM_MASTERS-1:0]    s_bvalid,
  input  logic [NUM_MASTERS-1:0]    s_bready,
  input  logic [NUM_MASTERS*52-1:0] s_ar_pld,
  input  logic [NUM_MASTERS-1:0]    s_arvalid,
  output logic [NUM_MASTERS-1:0]    s_arready,
  output logic [38:0]               s_r_pld,
  output logic [NUM_MASTERS-1:0]    s_rvalid,
  input  logic [NUM_MASTERS-1:0]    s_rready,
  output logic [53:0]               m_aw_pld,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [40:0]               m_w_pld,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [5:0]                m_b_pld,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [51:0]               m_ar_pld,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [38:0]               m_r_pld,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  output logic [NUM_MASTERS-1:0]    wr_grant,
  output logic [NUM_MASTERS-1:0]    rd_grant
);

  localparam int NM   = NUM_MASTERS;
  localparam int IDXW = $clog2(NUM_MASTERS);
  localparam int AW_W = 54;
  localparam int W_W  = 41;
  localparam int AR_W = 52;

  localparam logic [1:0] WIDLE = 2'd0;
  localparam logic [1:0] WADDR = 2'd1;
  localparam logic [1:0] WDATA = 2'd2;
  localparam logic [1:0] WRESP = 2'd3;

  localparam logic [1:0] RIDLE = 2'd0;
  localparam logic [1:0] RADDR = 2'd1;
  localparam logic [1:0] RDATA = 2'd2;

  localparam logic [IDXW-1:0] PTR_RST = IDXW'(NUM_MASTERS - 1);
  localparam logic [NM-1:0]   ONE     = {{(NM-1){1'b0}}, 1'b1};

  // Rank every requester by its distance after the last granted index;
  // distance 0 is last+1, so the lowest distance wins.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NM-1:0] req,
                                               input logic [IDXW-1:0] last);
    logic [IDXW-1:0] pick;
    int              best_d;
    int              d;
    pick   = last;
    best_d = NM;
    for (int i = 0; i < NM; i++) begin
      d = (i + NM - 1 - int'(last)) % NM;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        pick   = IDXW'(i);
      end
    end
    return pick;
  endfunction

  logic [1:0]      wr_state_q, wr_state_d;
  logic [NM-1:0]   wr_grant_q, wr_grant_d;
  logic [IDXW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [1:0]      rd_state_q, rd_state_d;
  logic [NM-1:0]   rd_grant_q, rd_grant_d;
  logic [IDXW-1:0] rd_ptr_q,   rd_ptr_d;

  assign wr_grant = wr_grant_q;
  assign rd_grant = rd_grant_q;

  // Channel muxes are gated by both grant and state, so every output is
  // zero whenever the path is idle or the channel is not the active one.
  always_comb begin
    m_aw_pld  = '0;
    m_awvalid = 1'b0;
    s_awready = '0;
    m_w_pld   = '0;
    m_wvalid  = 1'b0;
    s_wready  = '0;
    s_b_pld   = '0;
    s_bvalid  = '0;
    m_bready  = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (wr_grant_q[i]) begin
        if (wr_state_q == WADDR) begin
          m_aw_pld     = s_aw_pld[i*AW_W +: AW_W];
          m_awvalid    = s_awvalid[i];
          s_awready[i] = m_awready;
        end
        if (wr_state_q == WDATA) begin
          m_w_pld     = s_w_pld[i*W_W +: W_W];
          m_wvalid    = s_wvalid[i];
          s_wready[i] = m_wready;
        end
        if (wr_state_q == WRESP) begin
          s_b_pld     = m_b_pld;
          s_bvalid[i] = m_bvalid;
          m_bready    = s_bready[i];
        end
      end
    end
  end

  always_comb begin
    m_ar_pld  = '0;
    m_arvalid = 1'b0;
    s_arready = '0;
    s_r_pld   = '0;
    s_rvalid  = '0;
    m_rready  = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (rd_grant_q[i]) begin
        if (rd_state_q == RADDR) begin
          m_ar_pld     = s_ar_pld[i*AR_W +: AR_W];
          m_arvalid    = s_arvalid[i];
          s_arready[i] = m_arready;
        end
        if (rd_state_q == RDATA) begin
          s_r_pld     = m_r_pld;
          s_rvalid[i] = m_rvalid;
          m_rready    = s_rready[i];
        end
      end
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_grant_d = wr_grant_q;
    wr_ptr_d   = wr_ptr_q;
    case (wr_state_q)
      WIDLE: begin
        if (|s_awvalid) begin
          wr_ptr_d   = rr_pick(s_awvalid, wr_ptr_q);
          wr_grant_d = ONE << wr_ptr_d;
          wr_state_d = WADDR;
        end
      end
      WADDR: if (m_awvalid && m_awready) wr_state_d = WDATA;
      // Beat count is not tracked: only a last=1 handshake ends the burst.
      WDATA: if (m_wvalid && m_wready && m_w_pld[0]) wr_state_d = WRESP;
      WRESP: begin
        if (m_bvalid && m_bready) begin
          wr_grant_d = '0;
          wr_state_d = WIDLE;
        end
      end
      default: begin
        wr_grant_d = '0;
        wr_state_d = WIDLE;
      end
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_grant_d = rd_grant_q;
    rd_ptr_d   = rd_ptr_q;
    case (rd_state_q)
      RIDLE: begin
        if (|s_arvalid) begin
          rd_ptr_d   = rr_pick(s_arvalid, rd_ptr_q);
          rd_grant_d = ONE << rd_ptr_d;
          rd_state_d = RADDR;
        end
      end
      RADDR: if (m_arvalid && m_arready) rd_state_d = RDATA;
      RDATA: begin
        if (m_rvalid && m_rready && m_r_pld[0]) begin
          rd_grant_d = '0;
          rd_state_d = RIDLE;
        end
      end
      default: begin
        rd_grant_d = '0;
        rd_state_d = RIDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= WIDLE;
      wr_grant_q <= '0;
      wr_ptr_q   <= PTR_RST;
      rd_state_q <= RIDLE;
      rd_grant_q <= '0;
      rd_ptr_q   <= PTR_RST;
    end else begin
      wr_state_q <= wr_state_d;
      wr_grant_q <= wr_grant_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_state_q <= rd_state_d;
      rd_grant_q <= rd_grant_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_arbiter_axi4.sv
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_arbiter_axi4
// Purpose  : Directed self-checking bench for peripheral_arbiter_axi4 with
//            two masters. The bench plays both the masters and the slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_arbiter_axi4;

  localparam int NM = 2;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [NM*54-1:0] s_aw_pld;
  logic [NM-1:0]    s_awvalid, s_awready;
  logic [NM*41-1:0] s_w_pld;
  logic [NM-1:0]    s_wvalid, s_wready;
  logic [5:0]       s_b_pld;
  logic [NM-1:0]    s_bvalid, s_bready;
  logic [NM*52-1:0] s_ar_pld;
  logic [NM-1:0]    s_arvalid, s_arready;
  logic [38:0]      s_r_pld;
  logic [NM-1:0]    s_rvalid, s_rready;
  logic [53:0]      m_aw_pld;
  logic             m_awvalid, m_awready;
  logic [40:0]      m_w_pld;
  logic             m_wvalid, m_wready;
  logic [5:0]       m_b_pld;
  logic             m_bvalid, m_bready;
  logic [51:0]      m_ar_pld;
  logic             m_arvalid, m_arready;
  logic [38:0]      m_r_pld;
  logic             m_rvalid, m_rready;
  logic [NM-1:0]    wr_grant, rd_grant;
  logic             any_out;

  always #5 aclk = ~aclk;

  peripheral_arbiter_axi4 #(.NUM_MASTERS(NM)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_aw_pld(s_aw_pld), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_w_pld(s_w_pld), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_b_pld(s_b_pld), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_ar_pld(s_ar_pld), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_r_pld(s_r_pld), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_aw_pld(m_aw_pld), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_w_pld(m_w_pld), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_b_pld(m_b_pld), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_ar_pld(m_ar_pld), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_r_pld(m_r_pld), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  assign any_out = |{s_awready, s_wready, s_b_pld, s_bvalid, s_arready,
                     s_r_pld, s_rvalid, m_aw_pld, m_awvalid, m_w_pld,
                     m_wvalid, m_bready, m_ar_pld, m_arvalid, m_rready,
                     wr_grant, rd_grant};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] req;
    logic [1:0] g;
    int         n;
    bit         tog;
  } vec_t;

  vec_t wtab[8];
  vec_t rtab[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int gidx(input logic [1:0] g);
    return g[1] ? 1 : 0;
  endfunction

  function automatic logic [53:0] aw_of(input int m);
    return {4'(m + 5), 32'hA000_0000 | 32'(m), 4'd3, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0};
  endfunction

  function automatic logic [51:0] ar_of(input int m);
    return {4'(m + 9), 32'hB000_0000 | 32'(m), 4'd7, 3'd2, 2'd0, 4'd0, 3'd0};
  endfunction

  function automatic logic [40:0] w_of(input int m, input int b, input int n);
    return {4'(m + 5), 32'hD000_0000 + 32'(m*256 + b), 4'hF, (b == n - 1)};
  endfunction

  function automatic logic [38:0] r_of(input int m, input int b, input int n);
    return {4'(m + 9), 32'hC000_0000 + 32'(m*256 + b), 2'b00, (b == n - 1)};
  endfunction

  // Entered at posedge+1 of a write-idle cycle; leaves at posedge+1 of WDATA.
  task automatic aw_phase(input logic [1:0] req, input logic [1:0] g);
    s_awvalid = req;
    s_wvalid  = g;
    s_w_pld   = {w_of(1, 0, 1), w_of(0, 0, 1)};
    m_awready = 1'b0;
    m_wready  = 1'b1;
    @(negedge aclk);
    chk("idle_wr_grant", 64'(wr_grant), 64'(0));
    chk("idle_m_awvalid", 64'(m_awvalid), 64'(0));
    @(posedge aclk); #1;
    m_awready = 1'b1;
    @(negedge aclk);
    chk("wr_grant", 64'(wr_grant), 64'(g));
    chk("m_awvalid", 64'(m_awvalid), 64'(1));
    chk("m_aw_pld", 64'(m_aw_pld), 64'(aw_of(gidx(g))));
    chk("s_awready", 64'(s_awready), 64'(g));
    chk("early_s_wready", 64'(s_wready), 64'(0));
    chk("early_m_wvalid", 64'(m_wvalid), 64'(0));
    @(posedge aclk); #1;
    s_awvalid = req & ~g;
    m_awready = 1'b0;
    s_wvalid  = '0;
    m_wready  = 1'b0;
  endtask

  task automatic w_phase(input logic [1:0] g, input int nsend, input int n);
    for (int b = 0; b < nsend; b++) begin
      s_w_pld  = {w_of(1, b, n), w_of(0, b, n)};
      s_wvalid = 2'b11;
      m_wready = 1'b1;
      @(negedge aclk);
      chk("m_wvalid", 64'(m_wvalid), 64'(1));
      chk("m_w_pld", 64'(m_w_pld), 64'(w_of(gidx(g), b, n)));
      chk("s_wready", 64'(s_wready), 64'(g));
      @(posedge aclk); #1;
    end
    s_wvalid = '0;
    m_wready = 1'b0;
  endtask

  task automatic b_phase(input logic [1:0] g);
    m_bvalid = 1'b1;
    m_b_pld  = {4'(gidx(g) + 5), 2'b00};
    s_bready = 2'b11;
    @(negedge aclk);
    chk("s_bvalid", 64'(s_bvalid), 64'(g));
    chk("s_b_pld", 64'(s_b_pld), 64'({4'(gidx(g) + 5), 2'b00}));
    chk("m_bready", 64'(m_bready), 64'(1));
    @(posedge aclk); #1;
    m_bvalid = 1'b0;
    m_b_pld  = '0;
    s_bready = '0;
    chk("wr_release", 64'(wr_grant), 64'(0));
  endtask

  task automatic ar_phase(input logic [1:0] req, input logic [1:0] g);
    s_arvalid = req;
    m_arready = 1'b0;
    @(negedge aclk);
    chk("idle_rd_grant", 64'(rd_grant), 64'(0));
    chk("idle_m_arvalid", 64'(m_arvalid), 64'(0));
    @(posedge aclk); #1;
    m_arready = 1'b1;
    @(negedge aclk);
    chk("rd_grant", 64'(rd_grant), 64'(g));
    chk("m_arvalid", 64'(m_arvalid), 64'(1));
    chk("m_ar_pld", 64'(m_ar_pld), 64'(ar_of(gidx(g))));
    chk("s_arready", 64'(s_arready), 64'(g));
    @(posedge aclk); #1;
    s_arvalid = req & ~g;
    m_arready = 1'b0;
  endtask

  task automatic r_phase(input logic [1:0] g, input int n, input bit tog);
    int   beat;
    int   cyc;
    logic rr;
    beat = 0;
    cyc  = 0;
    rr   = tog ? 1'b0 : 1'b1;
    while (beat < n && cyc < 64) begin
      m_rvalid = 1'b1;
      m_r_pld  = r_of(gidx(g), beat, n);
      s_rready = rr ? 2'b11 : 2'b00;
      @(negedge aclk);
      chk("s_rvalid", 64'(s_rvalid), 64'(g));
      chk("s_r_pld", 64'(s_r_pld), 64'(r_of(gidx(g), beat, n)));
      chk("m_rready", 64'(m_rready), 64'(rr));
      @(posedge aclk); #1;
      if (rr) beat++;
      if (tog) rr = ~rr;
      cyc++;
    end
    m_rvalid = 1'b0;
    m_r_pld  = '0;
    s_rready = '0;
    chk("rd_release", 64'(rd_grant), 64'(0));
  endtask

  task automatic do_write(input vec_t v);
    aw_phase(v.req, v.g);
    w_phase(v.g, v.n, v.n);
    b_phase(v.g);
  endtask

  task automatic do_read(input vec_t v);
    ar_phase(v.req, v.g);
    r_phase(v.g, v.n, v.tog);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] wd;

    // Write-path arbitration; pointer starts at master 1 so master 0 leads.
    wtab[0] = '{2'b11, 2'b01, 1, 1'b0};
    wtab[1] = '{2'b11, 2'b10, 1, 1'b0};
    wtab[2] = '{2'b11, 2'b01, 2, 1'b0};
    wtab[3] = '{2'b11, 2'b10, 1, 1'b0};
    wtab[4] = '{2'b10, 2'b10, 4, 1'b0};
    wtab[5] = '{2'b01, 2'b01, 1, 1'b0};
    wtab[6] = '{2'b01, 2'b01, 1, 1'b0};
    wtab[7] = '{2'b10, 2'b10, 1, 1'b0};
    // Read path has its own pointer, still at master 1.
    rtab[0] = '{2'b11, 2'b01, 1, 1'b0};
    rtab[1] = '{2'b11, 2'b10, 8, 1'b1};
    rtab[2] = '{2'b01, 2'b01, 2, 1'b0};
    rtab[3] = '{2'b11, 2'b10, 1, 1'b0};

    aresetn   = 1'b0;
    s_aw_pld  = {aw_of(1), aw_of(0)};
    s_ar_pld  = {ar_of(1), ar_of(0)};
    s_w_pld   = '0;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0;
    s_arvalid = '0; s_rready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    m_b_pld   = '0; m_bvalid = 1'b0;
    m_r_pld   = '0; m_rvalid = 1'b0;

    repeat (2) @(posedge aclk);
    #1;
    chk("reset_outputs", 64'(any_out), 64'(0));
    chk("reset_wr_grant", 64'(wr_grant), 64'(0));
    chk("reset_rd_grant", 64'(rd_grant), 64'(0));
    aresetn = 1'b1;

    for (int i = 0; i < 8; i++) do_write(wtab[i]);
    for (int i = 0; i < 4; i++) do_read(rtab[i]);

    // Concurrent write from master 0 and read from master 1.
    wd        = 32'hD000_0000;
    s_awvalid = 2'b01;
    s_arvalid = 2'b10;
    @(posedge aclk); #1;
    m_awready = 1'b1;
    m_arready = 1'b1;
    @(negedge aclk);
    chk("cc_wr_grant", 64'(wr_grant), 64'(2'b01));
    chk("cc_rd_grant", 64'(rd_grant), 64'(2'b10));
    chk("cc_m_ar_pld", 64'(m_ar_pld), 64'(ar_of(1)));
    @(posedge aclk); #1;
    s_awvalid = '0; s_arvalid = '0;
    m_awready = 1'b0; m_arready = 1'b0;
    s_w_pld   = {w_of(1, 0, 1), w_of(0, 0, 1)};
    s_wvalid  = 2'b01;
    m_wready  = 1'b1;
    m_rvalid  = 1'b1;
    m_r_pld   = {4'd10, wd, 2'b00, 1'b1};
    s_rready  = 2'b10;
    @(negedge aclk);
    chk("cc_m_wdata", 64'(m_w_pld[36:5]), 64'(wd));
    chk("cc_s_rvalid", 64'(s_rvalid), 64'(2'b10));
    chk("cc_rdata", 64'(s_r_pld), 64'({4'd10, wd, 2'b00, 1'b1}));
    chk("cc_overlap", 64'({wr_grant, rd_grant}), 64'(4'b0110));
    @(posedge aclk); #1;
    s_wvalid = '0; m_wready = 1'b0;
    m_rvalid = 1'b0; m_r_pld = '0; s_rready = '0;
    chk("cc_rd_release", 64'(rd_grant), 64'(0));
    chk("cc_wr_busy", 64'(wr_grant), 64'(2'b01));
    b_phase(2'b01);

    // Reset while beat 2 of 4 from master 0 is on the W channel.
    aw_phase(2'b01, 2'b01);
    w_phase(2'b01, 2, 4);
    s_w_pld  = {w_of(1, 2, 4), w_of(0, 2, 4)};
    s_wvalid = 2'b11;
    m_wready = 1'b1;
    #1;
    chk("pre_rst_m_wvalid", 64'(m_wvalid), 64'(1));
    aresetn = 1'b0;
    #1;
    chk("abort_outputs", 64'(any_out), 64'(0));
    chk("abort_wr_grant", 64'(wr_grant), 64'(0));
    chk("abort_m_w_pld", 64'(m_w_pld), 64'(0));
    @(posedge aclk); #1;
    s_wvalid = '0;
    m_wready = 1'b0;
    aresetn  = 1'b1;
    do_write('{2'b11, 2'b01, 1, 1'b0});
    do_write('{2'b10, 2'b10, 4, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
